// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: CPU memory/IO bus controller decoding requests onto synchronous RAM,
// LED/switch registers and a compare-interrupt timer with a four-state handshake.
module mio_bus_ctrl #(
  parameter int RAM_AW = 10,
  parameter int LED_W  = 8,
  parameter int SW_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Wdata_in,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic              INT,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  output logic              ram_en,
  input  logic [31:0]       ram_dout,
  output logic [LED_W-1:0]  led_out,
  input  logic [SW_W-1:0]   sw_in
);
  typedef enum logic [1:0] {IDLE, ACC, DATA, RESP} state_t;
  state_t state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, data_q, data_d, cnt_q, cnt_d, cmp_q, cmp_d, rd_val, wa;
  logic [LED_W-1:0] led_q, led_d;
  logic we_q, we_d, pend_q, pend_d, take, wr;
  logic hit_ram, hit_led, hit_sw, hit_cnt, hit_cmp, hit_st;
  assign wa      = {addr_q, 2'b00};
  assign hit_ram = addr_q[31:RAM_AW+2] == '0;
  assign hit_led = wa == 32'hE000_0000;
  assign hit_sw  = wa == 32'hF000_0000;
  assign hit_cnt = wa == 32'hF000_0004;
  assign hit_cmp = wa == 32'hF000_0008;
  assign hit_st  = wa == 32'hF000_000C;
  assign take    = state_q == IDLE && CPU_MIO;
  assign wr      = state_q == ACC && we_q;
  always_comb begin
    state_d = state_q == IDLE ? (CPU_MIO ? ACC : IDLE) :
              state_q == ACC  ? DATA :
              state_q == DATA ? RESP : IDLE;
    addr_d  = take ? Addr_in[31:2] : addr_q;
    wdata_d = take ? Wdata_in : wdata_q;
    we_d    = take ? mem_w : we_q;
    rd_val  = hit_ram ? ram_dout :
              hit_led ? 32'(led_q) :
              hit_sw  ? 32'(sw_in) :
              hit_cnt ? cnt_q :
              hit_cmp ? cmp_q :
              hit_st  ? {31'b0, pend_q} : '0;
    data_d  = (state_q == DATA && !we_q) ? rd_val : data_q;
    led_d   = (wr && hit_led) ? wdata_q[LED_W-1:0] : led_q;
    cnt_d   = (wr && hit_cnt) ? wdata_q : cnt_q + 32'd1;
    cmp_d   = (wr && hit_cmp) ? wdata_q : cmp_q;
    // a match in the same cycle as a CPU clear keeps pending set
    pend_d  = (cnt_q == cmp_q && cmp_q != '0) || (pend_q && !(wr && hit_st && wdata_q[0]));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      data_q  <= data_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
    end
  end
  assign Data_in   = data_q;
  assign MIO_ready = state_q == RESP;
  assign INT       = pend_q;
  assign ram_en    = state_q == ACC && hit_ram;
  assign ram_we    = ram_en && we_q;
  assign ram_addr  = addr_q[RAM_AW+1:2];
  assign ram_din   = wdata_q;
  assign led_out   = led_q;
endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: directed bench for mio_bus_ctrl with a behavioural RAM and a
// read-data scoreboard popped on each MIO_ready pulse.
module tb_mio_bus_ctrl;
  logic        clk = 1'b0, reset = 1'b0, CPU_MIO = 1'b0, mem_w = 1'b0;
  logic [31:0] Addr_in = '0, Wdata_in = '0, Data_in, ram_din, ram_dout;
  logic        MIO_ready, INT, ram_we, ram_en;
  logic [9:0]  ram_addr;
  logic [7:0]  led_out;
  logic [15:0] sw_in = '0;
  logic [31:0] mem [1024];
  logic [31:0] exp_q [$];
  int n_cmp = 0, n_bad = 0;

  mio_bus_ctrl dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w), .Addr_in(Addr_in),
    .Wdata_in(Wdata_in), .Data_in(Data_in), .MIO_ready(MIO_ready), .INT(INT),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_en(ram_en),
    .ram_dout(ram_dout), .led_out(led_out), .sw_in(sw_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one full transaction driven from an IDLE negedge; inputs are scrambled after sampling
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    logic is_ram;
    int cyc;
    is_ram = a[31:12] == 20'h0;
    if (!w) exp_q.push_back(exp);
    CPU_MIO = 1'b1; mem_w = w; Addr_in = a; Wdata_in = d;
    @(negedge clk);
    cyc = 1;
    chk("ram_en_acc", 32'(ram_en), 32'(is_ram));
    chk("ram_we_acc", 32'(ram_we), 32'(is_ram && w));
    if (is_ram) chk("ram_addr", 32'(ram_addr), 32'(a[11:2]));
    CPU_MIO = 1'b0; mem_w = ~w; Addr_in = a ^ 32'hE000_0010; Wdata_in = ~d;
    while (!MIO_ready && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) chk("ram_en_we_data", {30'b0, ram_en, ram_we}, 32'd0);
    end
    chk("latency", 32'(cyc), 32'd3);
    if (MIO_ready && !w) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("rdata", Data_in, exp_q.pop_front());
    end
    @(negedge clk);
    chk("ready_single", 32'(MIO_ready), 32'd0);
  endtask

  initial begin
    bit seen, got;
    int prev, pulses;
    logic last;
    repeat (3) @(negedge clk);
    chk("rst_data", Data_in, 32'd0);
    chk("rst_ready", 32'(MIO_ready), 32'd0);
    chk("rst_int", 32'(INT), 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    // reset while an LED write sits in ACC: the write must not land
    CPU_MIO = 1'b1; mem_w = 1'b1; Addr_in = 32'hE000_0000; Wdata_in = 32'h55;
    @(negedge clk);
    CPU_MIO = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= MIO_ready; end
    chk("abort_wr_ready", 32'(seen), 32'd0);
    chk("abort_wr_led", 32'(led_out), 32'd0);
    access(1'b1, 32'h40, 32'h1234_5678, 32'h0);
    // reset while a RAM read sits in DATA
    CPU_MIO = 1'b1; mem_w = 1'b0; Addr_in = 32'h40;
    @(negedge clk);
    CPU_MIO = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= MIO_ready; end
    chk("abort_rd_ready", 32'(seen), 32'd0);
    chk("abort_rd_data", Data_in, 32'd0);
    chk("abort_rd_int", 32'(INT), 32'd0);
    access(1'b0, 32'h40, 32'h0, 32'h1234_5678);
    access(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0);
    access(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    access(1'b1, 32'h0, 32'h0BAD_F00D, 32'h0);
    access(1'b1, 32'hFFC, 32'hA5A5_A5A5, 32'h0);
    access(1'b1, 32'h1000, 32'h1111_1111, 32'h0);
    access(1'b0, 32'hFFC, 32'h0, 32'hA5A5_A5A5);
    access(1'b0, 32'h1000, 32'h0, 32'h0);
    access(1'b0, 32'h0, 32'h0, 32'h0BAD_F00D);
    access(1'b1, 32'hE000_0000, 32'h1A5, 32'h0);
    chk("led_out", 32'(led_out), 32'hA5);
    access(1'b0, 32'hE000_0000, 32'h0, 32'hA5);
    access(1'b0, 32'hE000_0003, 32'h0, 32'hA5);
    access(1'b0, 32'hE000_0004, 32'h0, 32'h0);
    sw_in = 16'h8001;
    access(1'b0, 32'hF000_0000, 32'h0, 32'h8001);
    access(1'b1, 32'hF000_0000, 32'hFFFF, 32'h0);
    access(1'b0, 32'hF000_0000, 32'h0, 32'h8001);
    access(1'b0, 32'h1234_5678, 32'h0, 32'h0);
    // timer compare interrupt
    access(1'b1, 32'hF000_0004, 32'h0, 32'h0);
    access(1'b1, 32'hF000_0008, 32'd20, 32'h0);
    access(1'b0, 32'hF000_0008, 32'h0, 32'd20);
    chk("int_before", 32'(INT), 32'd0);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); got = INT; end
    chk("int_rise", 32'(got), 32'd1);
    repeat (5) @(negedge clk);
    chk("int_hold", 32'(INT), 32'd1);
    access(1'b0, 32'hF000_000C, 32'h0, 32'h1);
    access(1'b1, 32'hF000_000C, 32'h0, 32'h0);
    chk("int_clr0", 32'(INT), 32'd1);
    access(1'b1, 32'hF000_000C, 32'h1, 32'h0);
    chk("int_clr1", 32'(INT), 32'd0);
    access(1'b0, 32'hF000_000C, 32'h0, 32'h0);
    access(1'b1, 32'hF000_0004, 32'hFFFF_FFF0, 32'h0);
    chk("int_prewrap", 32'(INT), 32'd0);
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin @(negedge clk); got = INT; end
    chk("int_wrap", 32'(got), 32'd1);
    // CPU_MIO held high: one single-cycle pulse every 4 cycles
    for (int i = 0; i < 10; i++) exp_q.push_back(32'hA5);
    CPU_MIO = 1'b1; mem_w = 1'b0; Addr_in = 32'hE000_0000;
    prev = -1; pulses = 0; last = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (MIO_ready) begin
        pulses++;
        chk("cont_width", 32'(last), 32'd0);
        if (prev >= 0) chk("cont_gap", 32'(i - prev), 32'd4);
        prev = i;
        chk("cont_sb", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("cont_rdata", Data_in, exp_q.pop_front());
      end
      last = MIO_ready;
    end
    CPU_MIO = 1'b0;
    chk("cont_pulses", 32'(pulses), 32'd10);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
